// File: rtl/fsmc_slave.sv
// FSMC slave front end: strobe/bus resync, single-word read/write decode.
// Define FSMC_AUTOINC_EN to post-increment MEM_ADDR after each access.
module fsmc_slave #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FSMC_NE,
  input  logic              FSMC_NADV,
  input  logic              FSMC_NOE,
  input  logic              FSMC_NWE,
  input  logic [DATA_W-1:0] FSMC_AD_IN,
  output logic [DATA_W-1:0] FSMC_AD_OUT,
  output logic              FSMC_AD_OE,
  output logic              MEM_READ_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              PROTO_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_REQ,
    S_RD_LATCH,
    S_RD_DRIVE,
    S_WR_WAIT,
    S_WR_COMMIT
  } state_t;

  // strobe vector bit order: {NE, NADV, NOE, NWE}
  logic [SYNC_STAGES-1:0][3:0]        strb_q, strb_d;
  logic [3:0]                         strb_prev_q, strb_prev_d;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] ad_q, ad_d;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdout_q, rdout_d;
  logic                oe_q, oe_d;
  logic                err_q, err_d;
  logic                ne_pend_q, ne_pend_d;

  logic [3:0]        strb_s;
  logic [3:0]        rise;
  logic [3:0]        fall;
  logic [DATA_W-1:0] ad_s;
  logic              ne_s, nwe_s, noe_s;
  logic              proto;

  assign strb_s = strb_q[SYNC_STAGES-1];
  assign ad_s   = ad_q[SYNC_STAGES-1];
  assign rise   = strb_s & ~strb_prev_q;
  assign fall   = ~strb_s & strb_prev_q;
  assign ne_s   = strb_s[3];
  assign noe_s  = strb_s[1];
  assign nwe_s  = strb_s[0];
  assign proto  = ~noe_s & ~nwe_s;

  // shift strobes and AD bus through equal-depth sync pipelines
  always_comb begin
    strb_d = {strb_q[SYNC_STAGES-2:0],
              {FSMC_NE, FSMC_NADV, FSMC_NOE, FSMC_NWE}};
    ad_d = {ad_q[SYNC_STAGES-2:0], FSMC_AD_IN};
    strb_prev_d = strb_s;
  end

  // sync and edge-detect registers, idle-high after reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      strb_q      <= '1;
      ad_q        <= '1;
      strb_prev_q <= '1;
    end else begin
      strb_q      <= strb_d;
      ad_q        <= ad_d;
      strb_prev_q <= strb_prev_d;
    end
  end

  // bus-cycle decoder: next state and datapath updates
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdout_d   = rdout_q;
    oe_d      = oe_q;
    err_d     = err_q;
    ne_pend_d = ne_pend_q;
    unique case (state_q)
      S_IDLE: begin
        ne_pend_d = 1'b0;
        if (rise[2] && !ne_s) begin
          addr_d  = ad_s[ADDR_W-1:0];
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rise[3]) begin
          state_d = S_IDLE;
        end else if (proto) begin
          err_d = 1'b1;
        end else if (rise[2] && !ne_s) begin
          addr_d = ad_s[ADDR_W-1:0];
        end else if (fall[1]) begin
          state_d = S_RD_REQ;
        end else if (fall[0]) begin
          wdata_d = ad_s;
          state_d = S_WR_WAIT;
        end
      end
      S_RD_REQ: begin
        if (rise[3]) begin
          state_d = S_IDLE;
        end else if (proto) begin
          err_d   = 1'b1;
          state_d = S_ADDR;
        end else begin
          state_d = S_RD_LATCH;
        end
      end
      S_RD_LATCH: begin
        if (rise[3]) begin
          state_d = S_IDLE;
        end else if (proto) begin
          err_d   = 1'b1;
          state_d = S_ADDR;
        end else begin
          rdout_d = MEM_RDATA;
          oe_d    = 1'b1;
          state_d = S_RD_DRIVE;
        end
      end
      S_RD_DRIVE: begin
        if (rise[3]) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end else if (proto) begin
          err_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = S_ADDR;
        end else if (rise[1]) begin
          oe_d    = 1'b0;
          state_d = S_ADDR;
`ifdef FSMC_AUTOINC_EN
          addr_d  = addr_q + ADDR_W'(1);
`endif
        end
      end
      S_WR_WAIT: begin
        if (rise[0]) begin
          ne_pend_d = rise[3];
          state_d   = S_WR_COMMIT;
        end else if (rise[3]) begin
          state_d = S_IDLE;
        end else if (proto) begin
          err_d   = 1'b1;
          state_d = S_ADDR;
        end else if (!nwe_s) begin
          wdata_d = ad_s;
        end
      end
      S_WR_COMMIT: begin
        ne_pend_d = 1'b0;
        state_d   = (ne_pend_q || rise[3]) ? S_IDLE : S_ADDR;
`ifdef FSMC_AUTOINC_EN
        addr_d    = addr_q + ADDR_W'(1);
`endif
      end
      default: begin
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // decoder state and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdout_q   <= '0;
      oe_q      <= 1'b0;
      err_q     <= 1'b0;
      ne_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdout_q   <= rdout_d;
      oe_q      <= oe_d;
      err_q     <= err_d;
      ne_pend_q <= ne_pend_d;
    end
  end

  assign FSMC_AD_OUT    = rdout_q;
  assign FSMC_AD_OE     = oe_q;
  assign MEM_READ_WRITE = (state_q != S_WR_COMMIT);
  assign MEM_ADDR       = addr_q;
  assign MEM_WDATA      = wdata_q;
  assign PROTO_ERR      = err_q;

endmodule

// File: tb/tb_fsmc_slave.sv
// Scoreboard bench for fsmc_slave: directed FSMC bus cycles,
// monitor pops expected buffer writes and pad read data.
module tb_fsmc_slave;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ne, nadv, noe, nwe;
  logic [DW-1:0] ad_in;
  logic [DW-1:0] ad_out;
  logic          ad_oe;
  logic          rw;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic [DW-1:0] mrdata;
  logic          perr;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vecs = 0;
  int errs = 0;
  logic [AW+DW-1:0] wq [$];
  logic [DW-1:0]    rq [$];

  fsmc_slave #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(S)) dut (
    .CLK(clk), .RESET(rst),
    .FSMC_NE(ne), .FSMC_NADV(nadv), .FSMC_NOE(noe), .FSMC_NWE(nwe),
    .FSMC_AD_IN(ad_in), .FSMC_AD_OUT(ad_out), .FSMC_AD_OE(ad_oe),
    .MEM_READ_WRITE(rw), .MEM_ADDR(maddr), .MEM_WDATA(mwdata),
    .MEM_RDATA(mrdata), .PROTO_ERR(perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rw) mem[maddr] <= mwdata;
    mrdata <= mem[maddr];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_oe(input logic v, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (ad_oe !== v && cnt < 20);
  endtask

  task automatic pins_idle();
    ne = 1'b1; nadv = 1'b1; noe = 1'b1; nwe = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_oe"},    ad_oe,  0);
    check({tag, "_rw"},    rw,     1);
    check({tag, "_addr"},  maddr,  0);
    check({tag, "_wdata"}, mwdata, 0);
    check({tag, "_adout"}, ad_out, 0);
    check({tag, "_err"},   perr,   0);
  endtask

  task automatic addr_phase(input logic [DW-1:0] a);
    ne = 1'b0; ad_in = a; nadv = 1'b0;
    wait_cyc(3);
    nadv = 1'b1;
    wait_cyc(4);
  endtask

  task automatic end_cycle();
    ne = 1'b1;
    wait_cyc(5);
  endtask

  task automatic wr_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wq.push_back({a, d});
    ad_in = d; nwe = 1'b0;
    wait_cyc(6);
    nwe = 1'b1; ad_in = ~d;
    wait_cyc(6);
  endtask

  task automatic rd_strobe(input logic [DW-1:0] d);
    int c;
    rq.push_back(d);
    noe = 1'b0;
    wait_oe(1'b1, c);
    check("rd_oe_latency", c, S + 3);
    wait_cyc(2);
    noe = 1'b1;
    wait_oe(1'b0, c);
    check("rd_oe_turnaround", c, S + 1);
    wait_cyc(3);
  endtask

  task automatic monitor();
    logic oe_prev;
    logic [AW+DW-1:0] w;
    logic [DW-1:0] r;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rw === 1'b0) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {4'h0, maddr, mwdata}, 32'hFFFFFFFF);
        end else begin
          w = wq.pop_front();
          check("write_commit", {4'h0, maddr, mwdata}, {4'h0, w});
        end
      end
      if (ad_oe === 1'b1 && !oe_prev) begin
        if (rq.size() == 0) begin
          check("unexpected_read", {16'h0, ad_out}, 32'hFFFFFFFF);
        end else begin
          r = rq.pop_front();
          check("read_data", {16'h0, ad_out}, {16'h0, r});
        end
      end
      oe_prev = ad_oe;
    end
  endtask

  initial begin
    int c;
    logic seen;
    pins_idle();
    ad_in = '0;
    rst = 1'b1;
    fork
      monitor();
    join_none
    wait_cyc(3);
    check_reset("reset");
    rst = 1'b0;
    wait_cyc(3);

    // single write, data changes mid-strobe; high addr bits ignored
    addr_phase(16'hF012);
    wq.push_back({12'h012, 16'hA5C3});
    ad_in = 16'h1111; nwe = 1'b0;
    wait_cyc(3);
    ad_in = 16'hA5C3;
    wait_cyc(3);
    nwe = 1'b1; ad_in = 16'hFFFF;
    wait_cyc(6);
    check("wr_addr_held", maddr, 12'h012);
    end_cycle();

    // read back
    addr_phase(16'h0012);
    rd_strobe(16'hA5C3);
    end_cycle();

    // three strobes under one NE from 0xFFF
    addr_phase(16'h0FFF);
`ifdef FSMC_AUTOINC_EN
    wr_strobe(12'hFFF, 16'h1001);
    wr_strobe(12'h000, 16'h2002);
    wr_strobe(12'h001, 16'h3003);
`else
    wr_strobe(12'hFFF, 16'h1001);
    wr_strobe(12'hFFF, 16'h2002);
    wr_strobe(12'hFFF, 16'h3003);
`endif
    end_cycle();
    check("burst_q_empty", wq.size(), 0);

    // NE and NWE rise together: commit once, then idle
    addr_phase(16'h00AB);
    wq.push_back({12'h0AB, 16'h3C3C});
    ad_in = 16'h3C3C; nwe = 1'b0;
    wait_cyc(6);
    ne = 1'b1; nwe = 1'b1; ad_in = 16'h0000;
    wait_cyc(6);
    check("ne_nwe_commit", wq.size(), 0);
    // strobe without address phase is ignored
    ne = 1'b0; ad_in = 16'h1234; nwe = 1'b0;
    wait_cyc(6);
    nwe = 1'b1;
    wait_cyc(6);
    end_cycle();
    check("idle_strobe_ignored", maddr, 12'h0AB);

    // NE rises during RD_LATCH: pad never driven
    addr_phase(16'h0012);
    noe = 1'b0;
    wait_cyc(2);
    ne = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (ad_oe) seen = 1'b1;
    end
    check("rd_abort_no_oe", seen, 0);
    #1;
    noe = 1'b1;
    wait_cyc(4);

    // reset during RD_DRIVE
    addr_phase(16'h0012);
    rq.push_back(16'hA5C3);
    noe = 1'b0;
    wait_oe(1'b1, c);
    check("rst_rd_oe_up", ad_oe, 1);
    wait_cyc(1);
    rst = 1'b1;
    pins_idle();
    #1;
    check_reset("rst_rd");
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);

    // reset during WR_WAIT
    addr_phase(16'h0055);
    ad_in = 16'h7777; nwe = 1'b0;
    wait_cyc(5);
    rst = 1'b1;
    pins_idle();
    #1;
    check_reset("rst_wr");
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(6);
    check("rst_wr_no_commit", mem[12'h055] === 16'h7777, 0);

    // NOE and NWE low together
    addr_phase(16'h0020);
    noe = 1'b0; nwe = 1'b0;
    wait_cyc(6);
    check("proto_set", perr, 1);
    noe = 1'b1; nwe = 1'b1;
    wait_cyc(5);
    wr_strobe(12'h020, 16'h5A5A);
    check("proto_sticky_wr", perr, 1);
    end_cycle();
    check("proto_sticky_ne", perr, 1);
    rst = 1'b1;
    #1;
    check("proto_rst_clear", perr, 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);

    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
